int2flt: RTL and testbench

- Sequential 16-bit two's-complement integer to IEEE-754 half-precision (binary16) converter.
- Sits directly upstream of the float-to-int stage: it produces the half-precision words that stage consumes. Shares the same data_mem byte interface and the same start/done handshake with the test bench.
- Reads a little-endian int16 from data memory, normalizes it iteratively (one shift per clock), rounds to nearest even, and writes the binary16 result back little-endian.

---
 rtl/int2flt.sv | 147 ++++++++++++++
 tb/tb_int2flt.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/int2flt.sv
// Sequential int16 -> IEEE-754 binary16 converter. Reads a little-endian int16
// from data memory, normalizes one bit per clock, rounds to nearest even, writes back.
module int2flt #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] IN_ADDR  = 8'd0,
    parameter logic [ADDR_W-1:0] OUT_ADDR = 8'd2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_wr_en,
    output logic [7:0]        dm_wdata,
    input  logic [7:0]        dm_rdata
);

    typedef enum logic [3:0] {
        IDLE, RD_LO, RD_HI, PREP, NORM, PACK, WR_LO, WR_HI, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] IN_ADDR_HI  = IN_ADDR + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OUT_ADDR_HI = OUT_ADDR + ADDR_W'(1);

    state_t      state, next_state;
    logic        start_q;
    logic        trig;
    logic [7:0]  lo, hi;
    logic        sign;
    logic [15:0] mag;
    logic [3:0]  s;
    logic [15:0] res;

    logic [15:0] mag_abs;
    logic [4:0]  exp_raw, exp_fin;
    logic [9:0]  frac;
    logic        guard, sticky, round_up;
    logic [10:0] frac_sum;
    logic [15:0] res_c;

    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;
    logic              wr_en_d, done_d;

    assign trig = start_q & ~start;

    // Negating 0x8000 wraps back to 0x8000, which is the right unsigned magnitude.
    assign mag_abs = hi[7] ? (16'd0 - {hi, lo}) : {hi, lo};

    assign exp_raw  = 5'd30 - {1'b0, s};
    assign frac     = mag[14:5];
    assign guard    = mag[4];
    assign sticky   = |mag[3:0];
    assign round_up = guard & (sticky | frac[0]);
    assign frac_sum = {1'b0, frac} + {10'd0, round_up};
    // A carry out leaves frac_sum[9:0] at zero, so only the exponent needs bumping.
    assign exp_fin  = exp_raw + {4'd0, frac_sum[10]};
    assign res_c    = (mag == 16'd0) ? 16'h0000 : {sign, exp_fin, frac_sum[9:0]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (trig) next_state = RD_LO;
            RD_LO:   next_state = RD_HI;
            RD_HI:   next_state = PREP;
            PREP:    next_state = (mag_abs == 16'd0 || mag_abs[15]) ? PACK : NORM;
            NORM:    if (mag[14]) next_state = PACK;
            PACK:    next_state = WR_LO;
            WR_LO:   next_state = WR_HI;
            WR_HI:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they are glitch-free.
    always_comb begin
        addr_d  = '0;
        wdata_d = '0;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        unique case (next_state)
            RD_LO: addr_d = IN_ADDR;
            RD_HI: addr_d = IN_ADDR_HI;
            WR_LO: begin
                addr_d  = OUT_ADDR;
                wdata_d = res_c[7:0];
                wr_en_d = 1'b1;
            end
            WR_HI: begin
                addr_d  = OUT_ADDR_HI;
                wdata_d = res[15:8];
                wr_en_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            done     <= 1'b0;
            dm_wr_en <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            state    <= next_state;
            start_q  <= start;
            done     <= done_d;
            dm_wr_en <= wr_en_d;
            dm_addr  <= addr_d;
            dm_wdata <= wdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo   <= '0;
            hi   <= '0;
            sign <= 1'b0;
            mag  <= '0;
            s    <= '0;
            res  <= '0;
        end else begin
            unique case (state)
                RD_LO: lo <= dm_rdata;
                RD_HI: hi <= dm_rdata;
                PREP: begin
                    sign <= hi[7];
                    mag  <= mag_abs;
                    s    <= 4'd0;
                end
                NORM: begin
                    mag <= {mag[14:0], 1'b0};
                    s   <= s + 4'd1;
                end
                PACK:    res <= res_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int2flt.sv
// Randomized scoreboard bench for int2flt: expected binary16 words and done
// times come from an arithmetic reference model and are checked by a monitor.
module tb_int2flt;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] dm_addr;
    logic       dm_wr_en;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata;

    logic [7:0] mem    [256];
    logic [7:0] golden [256];

    typedef struct {
        logic [15:0] res;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    int2flt #(.ADDR_W(8), .IN_ADDR(8'd0), .OUT_ADDR(8'd2)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .done     (done),
        .dm_addr  (dm_addr),
        .dm_wr_en (dm_wr_en),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) if (dm_wr_en) mem[dm_addr] <= dm_wdata;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: nearest-even rounding of |v| to an 11-bit significand.
    function automatic logic [15:0] ref_h(input logic [15:0] x, output int s);
        int v, a, e, q, r, sh, half;
        bit sg;
        v  = int'($signed(x));
        sg = (v < 0);
        a  = sg ? -v : v;
        s  = 0;
        if (a == 0) return 16'h0000;
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        s = 15 - e;
        if (e <= 10) begin
            q = a << (10 - e);
        end else begin
            sh   = e - 10;
            q    = a >> sh;
            r    = a - (q << sh);
            half = 1 << (sh - 1);
            if (r > half || (r == half && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end
        return {sg, 5'(e + 15), 10'(q - 1024)};
    endfunction

    // Monitor: compares memory contents and completion time whenever done is seen.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (dm_wr_en) check("wr_addr_range", 32'(dm_addr == 8'd2 || dm_addr == 8'd3), 32'd1);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", {16'd0, mem[3], mem[2]}, {16'd0, e.res});
                    check("done_latency", cyc, e.done_cyc);
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        check("timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic issue(input logic [15:0] val, input int hold);
        exp_t e;
        int   s;
        mem[0] = val[7:0];
        mem[1] = val[15:8];
        @(posedge clk);
        #1 start = 1'b1;
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
        e.res      = ref_h(val, s);
        e.done_cyc = cyc + 7 + s;
        sb.push_back(e);
    endtask

    logic [15:0] directed [9] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h8000, 16'h0801,
                                  16'h0803, 16'h7FFF, 16'hFC00, 16'h1234};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            golden[i] = 8'(i * 7 + 3);
        end
        #3;
        check("reset_done",  {31'd0, done},     32'd0);
        check("reset_wr_en", {31'd0, dm_wr_en}, 32'd0);
        check("reset_addr",  {24'd0, dm_addr},  32'd0);
        check("reset_wdata", {24'd0, dm_wdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (directed[i]) begin
            issue(directed[i], 1);
            wait_drain();
        end

        // Long start request: only its falling edge may trigger.
        issue(16'h00FF, 5);
        wait_drain();

        // Input bytes change after they have been read.
        issue(16'h8000, 1);
        repeat (4) @(posedge clk);
        #1 mem[0] = 8'hFF;
        mem[1] = 8'h7F;
        wait_drain();

        // A second start pulse while normalizing is ignored.
        issue(16'h0001, 1);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain();

        // Asynchronous reset in the middle of normalization.
        mem[2] = 8'hAA;
        mem[3] = 8'h55;
        issue(16'h0001, 1);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_done",  {31'd0, done},     32'd0);
        check("abort_wr_en", {31'd0, dm_wr_en}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (25) @(posedge clk);
        check("abort_mem_kept", {16'd0, mem[3], mem[2]}, 32'h0000_55AA);
        issue(16'hFFFF, 1);
        wait_drain();

        for (int n = 0; n < 40; n++) begin
            issue(16'($urandom), int'($urandom_range(1, 3)));
            wait_drain();
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        begin
            int diffs = 0;
            for (int i = 4; i < 256; i++) if (mem[i] !== golden[i]) diffs++;
            check("untouched_mem", diffs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
